// File: rtl/dram_ctrl_if.sv
// Request/response bundle between the processor's data port and dram_ctrl.
// The processor side drives the request fields; the controller returns data and status.
interface dram_ctrl_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ack;
    logic                  busy;
    logic                  err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, busy, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, busy, err
    );
endinterface

// File: rtl/dram_ctrl.sv
// Single-outstanding-request data memory with a programmable access latency.
// Out-of-range addresses are flagged with err instead of aliasing into the array.
module dram_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4096,
    parameter int LATENCY    = 2
) (
    input  logic       clk,
    input  logic       rst,
    dram_ctrl_if.slave bus
);
    localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [3:0]          CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  ack_q, ack_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic             access;
    logic             in_range;
    logic             mem_wr;
    logic             mem_rd;
    logic             oor;
    logic [IDX_W-1:0] mem_idx;

    // The access happens on the edge that leaves WAIT with the counter at zero.
    assign access   = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign in_range = {1'b0, addr_q} < DEPTH_W;
    assign mem_idx  = addr_q[IDX_W-1:0];
    assign mem_wr   = access && we_q && in_range && !rst;
    assign mem_rd   = access && !we_q && in_range;
    assign oor      = access && !in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = ack_q;
        busy_d  = busy_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    cnt_d   = CNT_INIT;
                    busy_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ack_d   = 1'b1;
                    err_d   = !in_range;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_idx] <= wdata_q;
        end
        if (rst) begin
            rdata_q <= '0;
        end else if (mem_rd) begin
            rdata_q <= mem[mem_idx];
        end else if (oor) begin
            rdata_q <= '0;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;
endmodule
